halut_result_collector: RTL and testbench
=========================================

# halut_result_collector

Sink for the decoder output lanes of the HALUT matmul datapath. Buffers each lane's per-cycle `valid`/`result`/`m_addr` beats in a small per-lane FIFO, because decoder lanes cannot be stalled. Drains the FIFOs through a round-robin arbiter into one valid/ready output stream tagged with a row index. Sits directly behind the matmul top and feeds the output writer / host interface.

## Interface
- `M`, `halut_pkg::M`: output columns per row.
- `DecoderUnits`, `halut_pkg::DecoderUnits`: decoders per lane.
- `DecUnitsX`, `M / DecoderUnits`: number of input lanes (derived, do not change).
- `MAddrWidth`, `$clog2(M)`: column address width (derived).
- `FifoDepth`, 4: entries per lane FIFO, power of two, ≥2.
- `RowCntWidth`, 16: row index width.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, synchronous, active-low.
- `valid_i[DecUnitsX]` in 1: lane beat valid (no backpressure).
- `result_i[DecUnitsX]` in 32: FP32 lane result.
- `m_addr_i[DecUnitsX]` in MAddrWidth: global column address.
- `clear_i` in 1: synchronous flush; same effect as reset.
- `out_valid_o` out 1: output beat valid.
- `out_ready_i` in 1: consumer ready.
- `out_result_o` out 32: result.
- `out_m_addr_o` out MAddrWidth: column address.
- `out_row_o` out RowCntWidth: row index of this beat.
- `row_done_o` out 1: one-cycle pulse after the M-th handshake of a row.
- `overflow_o[DecUnitsX]` out 1: sticky, lane dropped a beat.
- `busy_o` out 1: any FIFO non-empty or `out_valid_o` high.

## Operation
- **Reset / clear:** `rst_ni`=0 or `clear_i`=1 at an edge does the following:
  - empties all FIFOs;
  - zeroes `out_valid_o`, `out_result_o`, `out_m_addr_o`, `out_row_o`, `row_done_o`, `overflow_o`, `busy_o`, the beat counter, and the arbiter pointer (set to lane 0).
  - `clear_i` overrides pushes, pops and handshakes in the same cycle.
- **Push:** `valid_i[x]` writes `{result_i[x], m_addr_i[x]}` into FIFO x if FIFO x is not full, or if it is full and is popped in the same cycle.
  - Otherwise the beat is dropped and `overflow_o[x]` is set. It stays set until reset or clear.
- **Output stage:** one register. It loads when (`!out_valid_o || out_ready_i`) and at least one FIFO is non-empty.
  - A load pops the granted FIFO.
  - If no FIFO is non-empty and a handshake occurs, `out_valid_o` drops.
- **Arbiter:** round-robin.
  - Grants the first non-empty lane at or after the pointer, wrapping.
  - On a grant, pointer ← granted+1 mod DecUnitsX.
  - The pointer is unchanged when there is no grant.
- **Output stability:** while `out_valid_o && !out_ready_i`, all `out_*` outputs hold stable.
- **Row tracking:** handshake = `out_valid_o && out_ready_i`.
  - Beat counter (0..M-1) increments on each handshake.
  - On a handshake with counter == M-1: counter ← 0, row index ← row index+1 (wraps at 2^RowCntWidth), and `row_done_o`=1 next cycle only.
  - `out_row_o` is the row index latched when the beat is loaded into the output register.
- **Invariant:** per-lane order is preserved. Cross-lane order follows grant order only.

## Timing
- Latency: `valid_i[x]` sampled at edge t → FIFO entry at t → output register loaded at edge t+1 → `out_valid_o` high in cycle t+2 if the output stage is free.
- Throughput: one beat/cycle with `out_ready_i` held at 1.
- Total buffering per lane is FifoDepth entries, plus the shared output register.
- `row_done_o` is registered: high the cycle after the final handshake.
- `busy_o` is registered from next-state FIFO occupancy and `out_valid_o`.
- Reset/clear taking effect at edge t: all outputs hold reset values in cycle t+1.

## Test plan
Bench configuration: M=32, DecoderUnits=8, DecUnitsX=4, FifoDepth=4.
- **Single beat:** `valid_i[2]`=1 for one cycle, `result_i[2]`=32'h3F800000, `m_addr_i[2]`=9, ready=1 → `out_valid_o` high for exactly one cycle, 2 cycles later, with 3F800000 / 9 / row 0. `busy_o` returns to 0 afterwards.
- **Round-robin:** all 4 lanes valid for one cycle with results 0xA0..0xA3, ready=1 → 4 consecutive beats A0, A1, A2, A3.
  - A second burst on lanes 1 and 3 only → 0xB3 is not required first: order follows a pointer of 0, giving B1 then B3.
- **Overflow:** ready=0, lane 0 pushes 6 beats 1..6 on consecutive cycles.
  - Beat 1 goes to the output register, beats 2..5 fill the FIFO, beat 6 is dropped and `overflow_o[0]`=1.
  - Raise ready → exactly 5 beats, 1..5, in order; `overflow_o[0]` stays 1.
- **Full with simultaneous pop:** with lane 0 FIFO full and ready=1, push a beat in the same cycle as a pop → no drop, `overflow_o[0]` stays 0, and all beats emerge in order.
- **Row boundary:** stream 64 beats (16 per lane), ready=1 → `row_done_o` pulses twice, each one cycle after the 32nd and the 64th handshakes.
  - Beats 1–32 carry `out_row_o`=0; beats 33–64 carry `out_row_o`=1.
- **Clear mid-stream:** assert `clear_i` while ready=0, with 3 lanes holding data and `overflow_o[1]`=1 → the next cycle has `out_valid_o`=0, `overflow_o`=0 and `busy_o`=0. The next push restarts at row 0, counter 0, from lane 0.

Source files
------------

// File: rtl/halut_result_collector.sv
// Collects the non-stallable decoder lane beats into per-lane FIFOs and drains them
// round-robin into one valid/ready stream tagged with column address and row index.
module halut_result_collector #(
    parameter int unsigned M            = 32,
    parameter int unsigned DecoderUnits = 8,
    parameter int unsigned DecUnitsX    = M / DecoderUnits,
    parameter int unsigned MAddrWidth   = $clog2(M),
    parameter int unsigned FifoDepth    = 4,
    parameter int unsigned RowCntWidth  = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [DecUnitsX-1:0]                 valid_i,
    input  logic [DecUnitsX-1:0][31:0]           result_i,
    input  logic [DecUnitsX-1:0][MAddrWidth-1:0] m_addr_i,
    input  logic                                 clear_i,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    output logic [31:0]                          out_result_o,
    output logic [MAddrWidth-1:0]                out_m_addr_o,
    output logic [RowCntWidth-1:0]               out_row_o,
    output logic                                 row_done_o,
    output logic [DecUnitsX-1:0]                 overflow_o,
    output logic                                 busy_o
);
    localparam int          NLanes = int'(DecUnitsX);
    localparam int unsigned PtrW   = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int unsigned CntW   = PtrW + 1;
    localparam int unsigned LaneW  = (DecUnitsX > 1) ? $clog2(DecUnitsX) : 1;
    localparam int unsigned BeatW  = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned EntW   = 32 + MAddrWidth;

    logic [EntW-1:0]                r_mem [DecUnitsX][FifoDepth];
    logic [DecUnitsX-1:0][PtrW-1:0] r_wptr;
    logic [DecUnitsX-1:0][PtrW-1:0] r_rptr;
    logic [DecUnitsX-1:0][CntW-1:0] r_cnt;
    logic [LaneW-1:0]               r_rr_ptr;
    logic [BeatW-1:0]               r_beat_cnt;
    logic [RowCntWidth-1:0]         r_row_idx;

    logic [DecUnitsX-1:0]           w_nonempty;
    logic [DecUnitsX-1:0]           w_full;
    logic [DecUnitsX-1:0]           w_push;
    logic [DecUnitsX-1:0]           w_pop;
    logic [DecUnitsX-1:0]           w_drop;
    logic [DecUnitsX-1:0][CntW-1:0] w_cnt_nxt;
    logic [LaneW-1:0]               w_grant;
    logic [LaneW-1:0]               w_rr_nxt;
    logic                           w_grant_vld;
    logic                           w_load;
    logic                           w_hs;
    logic                           w_row_end;
    logic                           w_out_valid_nxt;
    logic                           w_busy_nxt;
    logic [RowCntWidth-1:0]         w_row_nxt;
    logic [EntW-1:0]                w_head;

    always_comb begin
        for (int x = 0; x < NLanes; x++) begin
            w_nonempty[x] = (r_cnt[x] != '0);
            w_full[x]     = (r_cnt[x] == CntW'(FifoDepth));
        end
    end

    // Round-robin search: first non-empty lane at or after the pointer, wrapping.
    always_comb begin
        int idx;
        w_grant     = '0;
        w_grant_vld = 1'b0;
        idx         = 0;
        for (int i = 0; i < NLanes; i++) begin
            idx = int'(r_rr_ptr) + i;
            if (idx >= NLanes) idx = idx - NLanes;
            if (!w_grant_vld && w_nonempty[idx]) begin
                w_grant_vld = 1'b1;
                w_grant     = LaneW'(idx);
            end
        end
    end

    assign w_head          = r_mem[w_grant][r_rptr[w_grant]];
    assign w_rr_nxt        = (w_grant == LaneW'(NLanes - 1)) ? '0 : w_grant + LaneW'(1);
    assign w_hs            = out_valid_o && out_ready_i;
    assign w_load          = (!out_valid_o || out_ready_i) && w_grant_vld;
    assign w_row_end       = (r_beat_cnt == BeatW'(M - 1));
    assign w_row_nxt       = (w_hs && w_row_end) ? r_row_idx + RowCntWidth'(1) : r_row_idx;
    assign w_out_valid_nxt = w_load || (out_valid_o && !out_ready_i);

    // A full FIFO still accepts a beat when the same edge pops it.
    always_comb begin
        w_busy_nxt = w_out_valid_nxt;
        for (int x = 0; x < NLanes; x++) begin
            w_pop[x]     = w_load && (w_grant == LaneW'(x));
            w_push[x]    = valid_i[x] && (!w_full[x] || w_pop[x]);
            w_drop[x]    = valid_i[x] && !w_push[x];
            w_cnt_nxt[x] = r_cnt[x] + CntW'(w_push[x]) - CntW'(w_pop[x]);
            if (w_cnt_nxt[x] != '0) w_busy_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int x = 0; x < NLanes; x++) begin
            if (w_push[x]) r_mem[x][r_wptr[x]] <= {result_i[x], m_addr_i[x]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_cnt        <= '0;
            r_rr_ptr     <= '0;
            r_beat_cnt   <= '0;
            r_row_idx    <= '0;
            overflow_o   <= '0;
            out_valid_o  <= 1'b0;
            out_result_o <= '0;
            out_m_addr_o <= '0;
            out_row_o    <= '0;
            row_done_o   <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            for (int x = 0; x < NLanes; x++) begin
                if (w_push[x]) r_wptr[x] <= r_wptr[x] + PtrW'(1);
                if (w_pop[x])  r_rptr[x] <= r_rptr[x] + PtrW'(1);
                if (w_drop[x]) overflow_o[x] <= 1'b1;
            end
            r_cnt <= w_cnt_nxt;
            if (w_grant_vld && w_load) r_rr_ptr <= w_rr_nxt;
            if (w_hs) r_beat_cnt <= w_row_end ? '0 : r_beat_cnt + BeatW'(1);
            r_row_idx   <= w_row_nxt;
            row_done_o  <= w_hs && w_row_end;
            out_valid_o <= w_out_valid_nxt;
            // A beat loaded on the edge that closes a row belongs to the next row.
            if (w_load) begin
                out_result_o <= w_head[EntW-1:MAddrWidth];
                out_m_addr_o <= w_head[MAddrWidth-1:0];
                out_row_o    <= w_row_nxt;
            end
            busy_o <= w_busy_nxt;
        end
    end
endmodule

// File: tb/tb_halut_result_collector.sv
// Bench for halut_result_collector: table vectors, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_halut_result_collector;
    localparam int M = 32, DU = 8, NX = 4, DEPTH = 4, AW = 5, RW = 16;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 clear;
    logic                 ready;
    logic [NX-1:0]        valid;
    logic [NX-1:0][31:0]  res;
    logic [NX-1:0][AW-1:0] addr;
    logic                 out_valid_o;
    logic [31:0]          out_result_o;
    logic [AW-1:0]        out_m_addr_o;
    logic [RW-1:0]        out_row_o;
    logic                 row_done_o;
    logic [NX-1:0]        overflow_o;
    logic                 busy_o;

    always #5 clk = ~clk;

    halut_result_collector #(
        .M(M), .DecoderUnits(DU), .FifoDepth(DEPTH), .RowCntWidth(RW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .result_i(res), .m_addr_i(addr),
        .clear_i(clear), .out_valid_o(out_valid_o), .out_ready_i(ready),
        .out_result_o(out_result_o), .out_m_addr_o(out_m_addr_o), .out_row_o(out_row_o),
        .row_done_o(row_done_o), .overflow_o(overflow_o), .busy_o(busy_o)
    );

    int n_cmp = 0, n_bad = 0;
    int hs_total = 0, n_done = 0;
    logic track_rows = 1'b0;
    logic [31:0] got_res[$];
    logic [RW-1:0] got_row[$];

    // Reference model state
    logic [36:0]   mq[NX][$];
    logic          m_ov, m_done, m_busy;
    logic [31:0]   m_res;
    logic [AW-1:0] m_addr;
    logic [RW-1:0] m_row, m_rowidx;
    logic [NX-1:0] m_ovf;
    int            m_cnt, m_ptr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [36:0] e;
        int g, l;
        bit any, hs, load;
        e = '0;
        if (!rst_n || clear) begin
            for (int x = 0; x < NX; x++) mq[x].delete();
            m_ov = 0; m_res = 0; m_addr = 0; m_row = 0; m_done = 0; m_ovf = 0;
            m_busy = 0; m_cnt = 0; m_rowidx = 0; m_ptr = 0;
            return;
        end
        hs = m_ov && ready;
        any = 0; g = 0;
        for (int i = 0; i < NX; i++) begin
            l = (m_ptr + i) % NX;
            if (!any && mq[l].size() != 0) begin any = 1; g = l; end
        end
        load = (!m_ov || ready) && any;
        if (load) begin e = mq[g].pop_front(); m_ptr = (g + 1) % NX; end
        for (int x = 0; x < NX; x++)
            if (valid[x]) begin
                if (mq[x].size() < DEPTH) mq[x].push_back({res[x], addr[x]});
                else m_ovf[x] = 1'b1;
            end
        m_done = 0;
        if (hs) begin
            if (m_cnt == M - 1) begin m_cnt = 0; m_rowidx = m_rowidx + 1'b1; m_done = 1; end
            else m_cnt++;
        end
        if (load) begin m_ov = 1; m_res = e[36:5]; m_addr = e[4:0]; m_row = m_rowidx; end
        else if (hs) m_ov = 0;
        m_busy = m_ov;
        for (int x = 0; x < NX; x++) if (mq[x].size() != 0) m_busy = 1;
    endtask

    task automatic cmp_model();
        check("out_valid", 32'(out_valid_o), 32'(m_ov));
        check("busy", 32'(busy_o), 32'(m_busy));
        check("row_done", 32'(row_done_o), 32'(m_done));
        check("overflow", 32'(overflow_o), 32'(m_ovf));
        if (m_ov) begin
            check("out_result", out_result_o, m_res);
            check("out_m_addr", 32'(out_m_addr_o), 32'(m_addr));
            check("out_row", 32'(out_row_o), 32'(m_row));
        end
    endtask

    task automatic tick();
        if (out_valid_o && ready && rst_n && !clear) begin
            got_res.push_back(out_result_o);
            got_row.push_back(out_row_o);
            hs_total++;
        end
        model_step();
        @(posedge clk); #1;
        cmp_model();
        if (row_done_o) begin
            n_done++;
            if (track_rows) check("row_done_pos", 32'(hs_total % 32), 32'd0);
        end
    endtask

    task automatic restart();
        valid = '0; clear = 1'b1; tick(); clear = 1'b0;
        got_res.delete(); got_row.delete(); hs_total = 0; n_done = 0;
    endtask

    typedef struct {
        logic [NX-1:0] vld; logic [31:0] base; logic [AW-1:0] abase;
        logic rdy; logic clr; logic e_vld; logic [31:0] e_res; logic [AW-1:0] e_addr; logic e_busy;
    } vec_t;
    vec_t tbl[14];

    function automatic vec_t mk(input logic [NX-1:0] v, input logic [31:0] b, input logic [AW-1:0] ab,
                                input logic r, input logic c, input logic ev, input logic [31:0] er,
                                input logic [AW-1:0] ea, input logic eb);
        vec_t t;
        t.vld = v; t.base = b; t.abase = ab; t.rdy = r; t.clr = c;
        t.e_vld = ev; t.e_res = er; t.e_addr = ea; t.e_busy = eb;
        return t;
    endfunction

    initial begin
        rst_n = 1'b0; clear = 1'b0; ready = 1'b0; valid = '0; res = '0; addr = '0;
        tick(); tick();
        check("rst_out_valid", 32'(out_valid_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_overflow", 32'(overflow_o), 0);
        check("rst_row_done", 32'(row_done_o), 0);
        check("rst_out_result", out_result_o, 0);
        check("rst_out_row", 32'(out_row_o), 0);
        rst_n = 1'b1;

        // Single beat, then clear, then round-robin bursts.
        tbl[0]  = mk(4'b0100, 32'h3F7FFFFE, 5'd7, 1, 0, 0, 0, 0, 1);
        tbl[1]  = mk(4'b0000, 0, 0, 1, 0, 1, 32'h3F800000, 5'd9, 1);
        tbl[2]  = mk(4'b0000, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[3]  = mk(4'b0000, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[4]  = mk(4'b0000, 0, 0, 1, 1, 0, 0, 0, 0);
        tbl[5]  = mk(4'b1111, 32'hA0, 5'd0, 1, 0, 0, 0, 0, 1);
        tbl[6]  = mk(4'b0000, 0, 0, 1, 0, 1, 32'hA0, 5'd0, 1);
        tbl[7]  = mk(4'b0000, 0, 0, 1, 0, 1, 32'hA1, 5'd1, 1);
        tbl[8]  = mk(4'b0000, 0, 0, 1, 0, 1, 32'hA2, 5'd2, 1);
        tbl[9]  = mk(4'b0000, 0, 0, 1, 0, 1, 32'hA3, 5'd3, 1);
        tbl[10] = mk(4'b1010, 32'hB0, 5'd10, 1, 0, 0, 0, 0, 1);
        tbl[11] = mk(4'b0000, 0, 0, 1, 0, 1, 32'hB1, 5'd11, 1);
        tbl[12] = mk(4'b0000, 0, 0, 1, 0, 1, 32'hB3, 5'd13, 1);
        tbl[13] = mk(4'b0000, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 14; i++) begin
            valid = tbl[i].vld; ready = tbl[i].rdy; clear = tbl[i].clr;
            for (int x = 0; x < NX; x++) begin
                res[x]  = tbl[i].base + 32'(x);
                addr[x] = tbl[i].abase + AW'(x);
            end
            tick();
            check("tbl_valid", 32'(out_valid_o), 32'(tbl[i].e_vld));
            check("tbl_busy", 32'(busy_o), 32'(tbl[i].e_busy));
            if (tbl[i].e_vld) begin
                check("tbl_result", out_result_o, tbl[i].e_res);
                check("tbl_addr", 32'(out_m_addr_o), 32'(tbl[i].e_addr));
                check("tbl_row", 32'(out_row_o), 0);
            end
        end
        valid = '0; clear = 1'b0;

        // Overflow: six beats into a stalled lane 0.
        restart(); ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            valid = 4'b0001; res[0] = 32'(k); addr[0] = AW'(k); tick();
        end
        valid = '0;
        check("ovf_set", 32'(overflow_o[0]), 1);
        ready = 1'b1;
        repeat (12) tick();
        check("ovf_count", 32'(got_res.size()), 5);
        for (int i = 0; i < got_res.size() && i < 5; i++) check("ovf_order", got_res[i], 32'(i + 1));
        check("ovf_sticky", 32'(overflow_o[0]), 1);

        // Full FIFO accepting a beat on the same edge it is popped.
        restart(); ready = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k == 6) ready = 1'b1;
            valid = 4'b0001; res[0] = 32'(k); addr[0] = AW'(k); tick();
        end
        valid = '0;
        repeat (12) tick();
        check("fullpop_count", 32'(got_res.size()), 8);
        for (int i = 0; i < got_res.size() && i < 8; i++) check("fullpop_order", got_res[i], 32'(i + 1));
        check("fullpop_no_ovf", 32'(overflow_o[0]), 0);

        // Row boundary: 64 beats, one lane per cycle.
        restart(); ready = 1'b1; track_rows = 1'b1;
        for (int k = 0; k < 64; k++) begin
            valid = 4'b0001 << (k % 4); res[k % 4] = 32'(k + 1); addr[k % 4] = AW'(k % 32); tick();
        end
        valid = '0;
        repeat (10) tick();
        track_rows = 1'b0;
        check("row_beats", 32'(got_res.size()), 64);
        check("row_done_count", 32'(n_done), 2);
        for (int i = 0; i < got_row.size(); i++) check("row_tag", 32'(got_row[i]), 32'(i / 32));

        // Clear mid-stream with three lanes holding data and lane 1 overflowed.
        restart(); ready = 1'b0;
        valid = 4'b0111; res[0] = 32'h10; res[1] = 32'h20; res[2] = 32'h30; tick();
        for (int k = 0; k < 6; k++) begin
            valid = 4'b0010; res[1] = 32'h21 + 32'(k); tick();
        end
        valid = '0;
        check("clr_pre_ovf", 32'(overflow_o[1]), 1);
        clear = 1'b1; tick(); clear = 1'b0;
        check("clr_out_valid", 32'(out_valid_o), 0);
        check("clr_overflow", 32'(overflow_o), 0);
        check("clr_busy", 32'(busy_o), 0);
        got_res.delete(); got_row.delete(); hs_total = 0;
        ready = 1'b1;
        valid = 4'b1001; res[0] = 32'h50; res[3] = 32'h53; addr[0] = 5'd1; addr[3] = 5'd2; tick();
        valid = '0;
        repeat (6) tick();
        check("clr_restart_count", 32'(got_res.size()), 2);
        if (got_res.size() >= 2) begin
            check("clr_restart_first", got_res[0], 32'h50);
            check("clr_restart_row", 32'(got_row[0]), 0);
            check("clr_restart_second", got_res[1], 32'h53);
        end

        // Randomized traffic against the model.
        restart();
        for (int c = 0; c < 3000; c++) begin
            for (int x = 0; x < NX; x++) begin
                valid[x] = ($urandom_range(0, 99) < ((c < 1500) ? 15 : 35));
                res[x]   = $urandom;
                addr[x]  = AW'($urandom);
            end
            ready = ($urandom_range(0, 99) < 70);
            clear = ($urandom_range(0, 299) == 0);
            tick();
        end
        valid = '0; clear = 1'b0;
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
